fabric_config_loader: RTL and testbench
=======================================

// Module: fabric_config_loader
// PURPOSE
//  Writes configuration into the fabric's config chain. Every logic tile LUT/FF-select word
//  and every switch-box crossbar word is linked into one serial scan chain.
//  The block receives a framed bitstream as a byte stream (valid/ready) from the host.
//  It checks the header, shifts payload bits into the chain, and verifies an XOR checksum.
//  The fabric copies chain contents into live config regs only on a single cfg_latch pulse.
//  A failed or aborted load therefore never corrupts the running configuration.
// PARAMETERS
//  NUM_TILES  16  logic tiles in chain
//  TILE_BITS  33  config bits per tile (32 LUT + 1 FF-select)
//  NUM_SBOX   40  4x4 switch boxes in chain
//  SBOX_BITS  16  config bits per switch box
//  derived: CHAIN_LEN = NUM_TILES*TILE_BITS + NUM_SBOX*SBOX_BITS; NBYTES = ceil(CHAIN_LEN/8)
// PORTS
//  clock         in   1  rising-edge clock
//  reset         in   1  asynchronous, active-high
//  start         in   1  pulse: begin a load (honoured only in IDLE/DONE/ERROR)
//  in_valid      in   1  host byte valid
//  in_data       in   8  host byte
//  in_ready      out  1  loader can accept byte this cycle
//  cfg_shift_en  out  1  chain shifts by one position this cycle
//  cfg_data      out  1  serial bit entering chain (meaningful when cfg_shift_en=1)
//  cfg_latch     out  1  one-cycle pulse: fabric copies chain into config regs
//  cfg_busy      out  1  load in progress (not IDLE/DONE/ERROR)
//  cfg_done      out  1  sticky: last load succeeded
//  cfg_error     out  1  sticky: last load failed
//  err_code      out  2  0 none, 1 bad header, 2 bad checksum
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters/checksum cleared.
//  - Frame format: 8'hA5 header, then NBYTES payload bytes, then 1 checksum byte.
//    The checksum is the XOR of all payload bytes.
//  - Bits are shifted LSB first, byte order as received.
//    The final payload byte shifts only CHAIN_LEN-8*(NBYTES-1) bits; its upper bits are ignored.
//  - A byte transfers on a clock edge where in_valid & in_ready.
//    in_data is not sampled otherwise. Gaps in in_valid are allowed anywhere.
//  - FSM states: IDLE, HDR, LOAD, SHIFT, CHK, LATCH, DONE, ERROR.
//  - IDLE/DONE/ERROR: in_ready=0.
//    On start: clear cfg_done, cfg_error, err_code and checksum, then go to HDR.
//    start is ignored while cfg_busy=1.
//  - HDR: in_ready=1.
//    Byte==A5 -> LOAD.
//    Any other byte -> ERROR with err_code=1. No shift, no latch.
//  - LOAD: in_ready=1.
//    Accepted byte -> load into serializer, XOR into checksum, decrement byte count, go to SHIFT.
//  - SHIFT: in_ready=0. cfg_shift_en=1 for exactly 8 cycles (fewer for the final partial byte).
//    Shifting starts the cycle after acceptance. Per-byte cost = 1 accept + 8 shift cycles.
//    After the last bit: go to LOAD if bytes remain, else CHK.
//  - CHK: in_ready=1.
//    Byte==checksum -> LATCH.
//    Mismatch -> ERROR with err_code=2. cfg_latch is never asserted on mismatch.
//  - LATCH: cfg_latch=1 for one cycle, then DONE with cfg_done=1.
//  - Total cfg_shift_en cycles per successful load = CHAIN_LEN exactly.
//  - cfg_busy=1 in HDR, LOAD, SHIFT, CHK and LATCH.
//  - Reset mid-load: immediate return to IDLE. No cfg_latch. The chain holds partial data,
//    which is harmless because live config regs are untouched.
//  - cfg_done and cfg_error are never 1 simultaneously.
// STRUCTURE
//  - Shared package fabric_cfg_pkg holds:
//    FSM state enum, CFG_HEADER=8'hA5, ERR_NONE/ERR_HDR/ERR_CSUM codes, and CHAIN_LEN/NBYTES functions.
//  - One sub-module, cfg_byte_serializer: 8-bit PISO with load, bit-count input and last-bit flag.
//    The FSM, byte counter and checksum stay in fabric_config_loader.
// TESTING  (scenarios 2-6 override NUM_TILES=1, NUM_SBOX=1 -> CHAIN_LEN=49, NBYTES=7, last byte 1 bit)
//  1 Reset asserted, random inputs -> all outputs 0, no in_ready, no shift_en.
//  2 start; A5, 01..07, checksum 00 -> 49 shift_en cycles.
//    cfg_data = bytes 01..06 LSB-first, then a single bit 1. One cfg_latch, then cfg_done=1, err_code=0.
//  3 start; header 5A -> cfg_error=1, err_code=1, zero shift_en, no cfg_latch, cfg_busy=0.
//  4 start; A5, 01..07, checksum FF -> 49 shifts, no cfg_latch, cfg_error=1, err_code=2.
//  5 in_valid held high continuously; random 0-5 cycle gaps -> in_ready low in every SHIFT cycle.
//    No byte is dropped or duplicated; cfg_data stream matches scenario 2.
//  6 reset after 3 payload bytes, then full valid load -> no cfg_latch before reset; second load matches scenario 2.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared types, constants and sizing helpers for the fabric configuration loader.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CHK   = 3'd4,
    ST_LATCH = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } cfg_state_t;

  localparam logic [7:0] CFG_HEADER = 8'hA5;
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_HDR    = 2'd1;
  localparam logic [1:0] ERR_CSUM   = 2'd2;

  function automatic int chain_len(input int num_tiles, input int tile_bits,
                                   input int num_sbox, input int sbox_bits);
    return num_tiles * tile_bits + num_sbox * sbox_bits;
  endfunction

  function automatic int nbytes(input int len);
    return (len + 7) / 8;
  endfunction

  // Bits carried by the final payload byte (1..8).
  function automatic int last_bits(input int len);
    return len - 8 * (nbytes(len) - 1);
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// 8-bit parallel-in serial-out shifter, LSB first, with a programmable bit count.
module cfg_byte_serializer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic [3:0] load_bits,
  input  logic       shift,
  output logic       bit_out,
  output logic       last_bit
);

  logic [7:0] shreg_r;
  logic [3:0] bits_r;

  // Shift register and remaining-bit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_r <= 8'd0;
      bits_r  <= 4'd0;
    end else if (load) begin
      shreg_r <= load_data;
      bits_r  <= load_bits;
    end else if (shift && (bits_r != 4'd0)) begin
      shreg_r <= {1'b0, shreg_r[7:1]};
      bits_r  <= bits_r - 4'd1;
    end else begin
      shreg_r <= shreg_r;
      bits_r  <= bits_r;
    end
  end

  assign bit_out  = shreg_r[0];
  assign last_bit = (bits_r == 4'd1);

endmodule

// File: rtl/fabric_config_loader.sv
// Loads a framed bitstream into the fabric config scan chain and latches it only after
// the header and XOR checksum have both been verified.
module fabric_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int TILE_BITS = 33,
  parameter int NUM_SBOX  = 40,
  parameter int SBOX_BITS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       cfg_shift_en,
  output logic       cfg_data,
  output logic       cfg_latch,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [1:0] err_code
);

  localparam int CHAIN_LEN = chain_len(NUM_TILES, TILE_BITS, NUM_SBOX, SBOX_BITS);
  localparam int NBYTES    = nbytes(CHAIN_LEN);
  localparam int CNT_W     = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] NBYTES_C    = CNT_W'(NBYTES);
  localparam logic [3:0]       LAST_BITS_C = 4'(last_bits(CHAIN_LEN));

  cfg_state_t       state_r, state_s;
  logic [CNT_W-1:0] byte_cnt_r, byte_cnt_s;
  logic [7:0]       csum_r, csum_s;
  logic             done_r, done_s;
  logic             error_r, error_s;
  logic [1:0]       err_code_r, err_code_s;
  logic             in_ready_s, accept_s;
  logic             ser_load_s, ser_shift_s, ser_bit_s, ser_last_s;
  logic [3:0]       ser_bits_s;

  // Moore decode of handshake readiness.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_HDR, ST_LOAD, ST_CHK: in_ready_s = 1'b1;
      default:                 in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready_s;

  // Next-state, counter, checksum and sticky-status logic.
  always_comb begin
    state_s     = state_r;
    byte_cnt_s  = byte_cnt_r;
    csum_s      = csum_r;
    done_s      = done_r;
    error_s     = error_r;
    err_code_s  = err_code_r;
    ser_load_s  = 1'b0;
    ser_bits_s  = 4'd8;
    ser_shift_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          done_s     = 1'b0;
          error_s    = 1'b0;
          err_code_s = ERR_NONE;
          csum_s     = 8'd0;
          byte_cnt_s = NBYTES_C;
          state_s    = ST_HDR;
        end else begin
          state_s = state_r;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          if (in_data == CFG_HEADER) begin
            state_s = ST_LOAD;
          end else begin
            error_s    = 1'b1;
            err_code_s = ERR_HDR;
            state_s    = ST_ERROR;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          ser_load_s = 1'b1;
          ser_bits_s = (byte_cnt_r == CNT_W'(1)) ? LAST_BITS_C : 4'd8;
          csum_s     = csum_update(csum_r, in_data);
          byte_cnt_s = byte_cnt_r - CNT_W'(1);
          state_s    = ST_SHIFT;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        ser_shift_s = 1'b1;
        if (ser_last_s) begin
          state_s = (byte_cnt_r == CNT_W'(0)) ? ST_CHK : ST_LOAD;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            state_s = ST_LATCH;
          end else begin
            error_s    = 1'b1;
            err_code_s = ERR_CSUM;
            state_s    = ST_ERROR;
          end
        end else begin
          state_s = ST_CHK;
        end
      end
      ST_LATCH: begin
        done_s  = 1'b1;
        state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      byte_cnt_r <= '0;
      csum_r     <= 8'd0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      csum_r     <= csum_s;
      done_r     <= done_s;
      error_r    <= error_s;
      err_code_r <= err_code_s;
    end
  end

  cfg_byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load_s),
    .load_data (in_data),
    .load_bits (ser_bits_s),
    .shift     (ser_shift_s),
    .bit_out   (ser_bit_s),
    .last_bit  (ser_last_s)
  );

  assign in_ready     = in_ready_s;
  assign cfg_shift_en = (state_r == ST_SHIFT);
  // Data line held low outside SHIFT so the chain sees a quiet input.
  assign cfg_data     = (state_r == ST_SHIFT) ? ser_bit_s : 1'b0;
  assign cfg_latch    = (state_r == ST_LATCH);
  assign cfg_busy     = (state_r == ST_HDR) || (state_r == ST_LOAD) || (state_r == ST_SHIFT) ||
                        (state_r == ST_CHK) || (state_r == ST_LATCH);
  assign cfg_done     = done_r;
  assign cfg_error    = error_r;
  assign err_code     = err_code_r;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed, table-driven bench for fabric_config_loader with a 49-bit chain.
module tb_fabric_config_loader;

  logic       clock;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cfg_shift_en;
  logic       cfg_data;
  logic       cfg_latch;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_error;
  logic [1:0] err_code;

  fabric_config_loader #(
    .NUM_TILES (1),
    .TILE_BITS (33),
    .NUM_SBOX  (1),
    .SBOX_BITS (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cfg_shift_en (cfg_shift_en),
    .cfg_data     (cfg_data),
    .cfg_latch    (cfg_latch),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .err_code     (err_code)
  );

  typedef struct {
    logic [7:0] hdr;
    int         npay;
    logic [7:0] csum;
    int         gap_max;
    bit         hold;
    bit         exp_done;
    bit         exp_err;
    int         exp_code;
    int         exp_shifts;
    int         exp_latch;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   shift_q[$];
  bit   exp_stream[$];
  int   latch_cnt = 0;
  int   ready_viol = 0;
  int   both_viol = 0;
  vec_t vecs[5];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe chain activity away from the active edge.
  always @(negedge clock) begin
    if (cfg_shift_en) begin
      shift_q.push_back(cfg_data);
      if (in_ready) ready_viol++;
    end
    if (cfg_latch) latch_cnt++;
    if (cfg_done && cfg_error) both_viol++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit hold);
    int n;
    if (!hold) begin
      in_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      chk("handshake_timeout", n, 0);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int mism;
    shift_q.delete();
    latch_cnt = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, int'(cfg_busy), 1);
    send_byte(v.hdr, v.gap_max, v.hold);
    for (int i = 0; i < v.npay; i++) send_byte(8'(i + 1), v.gap_max, v.hold);
    if (v.npay > 0) send_byte(v.csum, v.gap_max, v.hold);
    in_valid = 1'b0;
    n = 0;
    while (cfg_busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk({tag, "_busy_timeout"}, n, 0);
    @(negedge clock);
    chk({tag, "_done"},   int'(cfg_done),  int'(v.exp_done));
    chk({tag, "_error"},  int'(cfg_error), int'(v.exp_err));
    chk({tag, "_code"},   int'(err_code),  v.exp_code);
    chk({tag, "_shifts"}, shift_q.size(), v.exp_shifts);
    chk({tag, "_latch"},  latch_cnt, v.exp_latch);
    chk({tag, "_busy"},   int'(cfg_busy), 0);
    if (v.exp_shifts == exp_stream.size() && shift_q.size() == exp_stream.size()) begin
      mism = 0;
      for (int i = 0; i < exp_stream.size(); i++)
        if (shift_q[i] != exp_stream[i]) mism++;
      chk({tag, "_stream_mismatches"}, mism, 0);
    end
  endtask

  initial begin
    int n;
    logic [7:0] b;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    // Bytes 01..06 fully, then one bit of byte 07.
    for (int i = 1; i <= 7; i++) begin
      b = 8'(i);
      for (int k = 0; k < ((i == 7) ? 1 : 8); k++) exp_stream.push_back(b[k]);
    end

    //          hdr    np csum   gap hold done err code shifts latch
    vecs[0] = '{8'hA5, 7, 8'h00, 0, 1'b0, 1'b1, 1'b0, 0, 49, 1};
    vecs[1] = '{8'h5A, 0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1, 0,  0};
    vecs[2] = '{8'hA5, 7, 8'hFF, 0, 1'b0, 1'b0, 1'b1, 2, 49, 0};
    vecs[3] = '{8'hA5, 7, 8'h00, 0, 1'b1, 1'b1, 1'b0, 0, 49, 1};
    vecs[4] = '{8'hA5, 7, 8'h00, 5, 1'b0, 1'b1, 1'b0, 0, 49, 1};

    // Reset held with random inputs: every output stays low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      start    = 1'($urandom_range(1, 0));
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 8'($urandom_range(255, 0));
      #2;
      chk("reset_outputs", int'({in_ready, cfg_shift_en, cfg_data, cfg_latch, cfg_busy,
                                 cfg_done, cfg_error, err_code}), 0);
    end
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    chk("idle_busy", int'(cfg_busy), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a load, then a clean reload.
    shift_q.delete();
    latch_cnt = 0;
    pulse_start();
    send_byte(8'hA5, 0, 1'b0);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", int'({in_ready, cfg_shift_en, cfg_data, cfg_latch, cfg_busy,
                                   cfg_done, cfg_error, err_code}), 0);
    chk("midreset_no_latch", latch_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    run_vec(vecs[0], "reload");

    chk("ready_during_shift", ready_viol, 0);
    chk("done_and_error", both_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
